mxu_seq: RTL and testbench
==========================

# mxu_seq

Sequential DIM×DIM unsigned matrix-multiply unit computing Y = A·B. It is the compute engine behind the MXU trace bench, which loads operand pairs from trace files and presents them through this interface. Operands are latched on a one-cycle `in_valid` strobe. One inner-product term per output element is accumulated each cycle, and the result is held on `out` with a one-cycle `finished` pulse.

## Interface
- `DIM`, 4: matrix dimension; must be ≥ 1.
- `WIDTH`, 8: operand element width, unsigned.
- `OUT_WIDTH`, 2*WIDTH+$clog2(DIM): result element width. With DIM=1 this is 2*WIDTH.
- `clk`  in  1: sole clock; everything is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: one-cycle strobe marking `in0`/`in1` as valid.
- `in0`  in  DIM×DIM×WIDTH: matrix A, packed `[row][col]`.
- `in1`  in  DIM×DIM×WIDTH: matrix B, packed `[row][col]`.
- `out`  out  DIM×DIM×OUT_WIDTH: matrix Y, packed `[row][col]`, registered.
- `finished`  out  1: one-cycle pulse when `out` updates with a new result.
- `busy`  out  1: high while a computation is in flight.

## Operation
- States:
  - IDLE: `busy`=0.
  - COMPUTE: `busy`=1; index counter `k` runs 0..DIM-1, width max(1,$clog2(DIM)).
- IDLE & `in_valid`:
  - Latch A and B into internal registers.
  - Clear the DIM×DIM accumulators and set `k`=0.
  - Go to COMPUTE.
- IDLE & !`in_valid`: hold state; `out` keeps its last value.
- COMPUTE, each cycle:
  - For every (r,c): acc[r][c] += A[r][k]·B[k][c].
  - Products are full 2*WIDTH unsigned; accumulators are OUT_WIDTH wide.
- COMPUTE at `k`=DIM-1:
  - Write out[r][c] = acc[r][c] + A[r][DIM-1]·B[DIM-1][c].
  - Assert `finished` for the following cycle.
  - Return to IDLE.
- COMPUTE at `k`<DIM-1: increment `k`.
- `in_valid` while `busy`=1: ignored. No latch, no error flag, and the running computation is unaffected. The input ports may change freely during COMPUTE because operands are latched.
- Arithmetic is unsigned throughout. If OUT_WIDTH is overridden below the default, sums wrap modulo 2^OUT_WIDTH with no saturation. At the default width the result cannot overflow.
- DIM=1: COMPUTE lasts one cycle, giving a single product.

## Timing
- Reset values (immediate on `reset_n` low): state IDLE, `out`=0, `finished`=0, `busy`=0, `k`=0, accumulators and latched operands 0.
- Accept at edge T0: `busy` goes high after T0.
- MAC terms k=0..DIM-1 are performed at edges T1..T_DIM.
- After edge T_DIM: `out` is valid, `finished`=1 and `busy`=0 for exactly one cycle. Latency is DIM cycles from the accept edge.
- `out` remains stable until the next result is written; it is not cleared by `finished` deasserting.
- A new `in_valid` may be accepted on edge T_DIM+1, the same cycle `finished` is high. Back-to-back throughput is one matrix per DIM+1 cycles.
- `finished` and an accept on the same edge: legal. The pulse drops and `busy` rises; `out` still holds the previous result until the new computation completes.
- Reset mid-COMPUTE: the operation is aborted, no `finished` is produced, and `out` returns to 0.
- Reset released with `in_valid` high: acceptance is sampled at the first rising edge where `reset_n`=1.

## Test plan
- Identity: DIM=4, WIDTH=8, A=I, B[r][c]=4r+c, one `in_valid` strobe.
  - `finished` is a single pulse exactly 4 cycles after the accept edge.
  - Y=B.
- Max values: all A and B elements = 255.
  - Every Y element = 260100 (0x3F804), which fits in 18 bits.
- Back-to-back: pair1 (A=I, B=all 2), pair2 (A=all 1, B=all 3), with pair2 strobed in the `finished` cycle of pair1.
  - Y1 is all 2 and Y2 is all 12.
  - The two `finished` pulses are 5 cycles apart.
- Busy ignore: strobe `in_valid` with A=all 1, B=all 1, then strobe again 2 cycles later with A=all 7.
  - Y = all 4.
  - Only one `finished` pulse is produced.
  - `out` is unchanged afterwards.
- Reset mid-op: assert `reset_n`=0 at cycle 2 of COMPUTE, between clock edges.
  - `out`=0, `finished`=0 and `busy`=0 immediately, with no pulse later.
  - A following accept with A=I, B=all 5 yields all 5.
- Wrap: OUT_WIDTH=8 override, all A and B elements = 16.
  - Each sum is 1024, so every Y element = 0.

Source files
------------

// File: rtl/mxu_seq.sv
// Sequential DIM x DIM unsigned matrix multiply Y = A*B.
// Each cycle adds one inner-product term to every output element. Elements are packed [row][col], with element (r,c) at bit offset (r*DIM+c)*width.
module mxu_seq #(
    parameter int unsigned DIM       = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned OUT_WIDTH = 2 * WIDTH + $clog2(DIM)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic [DIM*DIM*WIDTH-1:0]       in0,
    input  logic [DIM*DIM*WIDTH-1:0]       in1,
    output logic [DIM*DIM*OUT_WIDTH-1:0]   out,
    output logic                           finished,
    output logic                           busy
);

    localparam int unsigned KW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic {S_IDLE, S_COMPUTE} state_t;

    typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0]     opnd_t;
    typedef logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] res_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    opnd_t         a_q, a_d, b_q, b_d;
    res_t          acc_q, acc_d, out_q, out_d, mac;
    logic          fin_q, fin_d, busy_q, busy_d;

    // One MAC step for all elements using the current inner index k
    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            assign mac[r][c] = acc_q[r][c]
                + OUT_WIDTH'(PW'(a_q[r][k_q]) * PW'(b_q[k_q][c]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        fin_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in0;
                    b_d     = in1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                acc_d = mac;
                if (k_q == KW'(DIM - 1)) begin
                    out_d   = mac;
                    fin_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_COMPUTE);
    end

    assign out      = out_q;
    assign finished = fin_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mxu_seq.sv
// Bench for mxu_seq: directed and random matrices checked against an arithmetic reference product.
// A second instance with an 8-bit result width exercises wrap-around.
module tb_mxu_seq;

    localparam int unsigned DIM   = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned OW    = 2 * WIDTH + $clog2(DIM);
    localparam int unsigned OW8   = 8;
    localparam int unsigned MW    = DIM * DIM * WIDTH;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic [MW-1:0]           in0 = '0;
    logic [MW-1:0]           in1 = '0;
    logic [DIM*DIM*OW-1:0]   out;
    logic [DIM*DIM*OW8-1:0]  out8;
    logic                    finished, busy, fin8, busy8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mxu_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in0(in0), .in1(in1),
        .out(out), .finished(finished), .busy(busy)
    );

    mxu_seq #(.DIM(DIM), .WIDTH(WIDTH), .OUT_WIDTH(OW8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in0(in0), .in1(in1),
        .out(out8), .finished(fin8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference product, each element reduced modulo 2^ow
    function automatic logic [511:0] ref_mul(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                             input int ow);
        logic [511:0]    res;
        longint unsigned s, mask;
        res  = '0;
        mask = (64'd1 << ow) - 64'd1;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                s = 0;
                for (int k = 0; k < DIM; k++)
                    s += longint'(a[(r*DIM+k)*WIDTH +: WIDTH]) * longint'(b[(k*DIM+c)*WIDTH +: WIDTH]);
                res |= 512'(s & mask) << ((r * DIM + c) * ow);
            end
        end
        return res;
    endfunction

    function automatic logic [MW-1:0] fill(input int v);
        logic [MW-1:0] m;
        for (int i = 0; i < DIM * DIM; i++) m[i*WIDTH +: WIDTH] = WIDTH'(v);
        return m;
    endfunction

    function automatic logic [MW-1:0] ident();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < DIM; i++) m[(i*DIM+i)*WIDTH +: WIDTH] = WIDTH'(1);
        return m;
    endfunction

    function automatic logic [MW-1:0] rnd();
        logic [MW-1:0] m;
        for (int i = 0; i < DIM * DIM; i++) m[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return m;
    endfunction

    // Present operands for one accept edge, then scramble the ports
    task automatic strobe(input logic [MW-1:0] a, input logic [MW-1:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in0 = a;
        in1 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in0 = rnd();
        in1 = rnd();
    endtask

    task automatic wait_fin(input string tag, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!finished && lat < 20);
        if (!finished) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [511:0] exp, exp8;
        int lat;
        exp  = ref_mul(a, b, OW);
        exp8 = ref_mul(a, b, OW8);
        strobe(a, b);
        check({tag, "_busy_hi"}, busy, 1);
        wait_fin(tag, lat);
        check({tag, "_latency"}, lat, DIM);
        check({tag, "_out"}, out, exp);
        check({tag, "_out8"}, out8, exp8);
        check({tag, "_busy_lo"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, finished, 0);
        check({tag, "_hold"}, out, exp);
    endtask

    initial begin
        logic [MW-1:0] bseq, ra, rb;
        logic [511:0]  y1;
        int lat, pulses;

        #2;
        check("rst_out", out, 0);
        check("rst_fin", finished, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < DIM * DIM; i++) bseq[i*WIDTH +: WIDTH] = WIDTH'(i);
        run_op("ident", ident(), bseq);
        run_op("max", fill(255), fill(255));
        check("max_elem", out[OW-1:0], 260100);

        // Second pair strobed in the finished cycle of the first
        strobe(ident(), fill(2));
        wait_fin("b2b1", lat);
        y1 = ref_mul(ident(), fill(2), OW);
        check("b2b_y1", out, y1);
        in_valid = 1'b1;
        in0 = fill(1);
        in1 = fill(3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_fin_drop", finished, 0);
        check("b2b_busy", busy, 1);
        check("b2b_hold_y1", out, y1);
        wait_fin("b2b2", lat);
        check("b2b_gap", lat + 1, DIM + 1);
        check("b2b_y2", out, ref_mul(fill(1), fill(3), OW));

        // Strobe while busy must be ignored
        strobe(fill(1), fill(1));
        @(posedge clk);
        strobe(fill(7), fill(1));
        wait_fin("ign", lat);
        check("ign_out", out, ref_mul(fill(1), fill(1), OW));
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (finished) pulses++;
        end
        check("ign_pulses", pulses, 0);
        check("ign_hold", out, ref_mul(fill(1), fill(1), OW));

        // Abort mid-computation, then release reset with in_valid already high
        strobe(fill(3), fill(3));
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rmid_out", out, 0);
        check("rmid_out8", out8, 0);
        check("rmid_fin", finished, 0);
        check("rmid_busy", busy, 0);
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (finished) pulses++;
        end
        check("rmid_nopulse", pulses, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in0 = ident();
        in1 = fill(5);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rrel_busy", busy, 1);
        wait_fin("rrel", lat);
        check("rrel_lat", lat, DIM);
        check("rrel_out", out, ref_mul(ident(), fill(5), OW));

        run_op("wrap", fill(16), fill(16));
        check("wrap_zero", out8, 0);

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            ra = rnd();
            rb = rnd();
            run_op($sformatf("rnd%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
